cpu_run_controller: RTL

- Sequences the single-cycle RISC-V core from the FPGA board clock.
- Takes the tick pulse from the tick generator, plus the GO push-button, a step-mode switch and the core's HALT indication.
- Produces a clock-enable pulse per CPU cycle, a CPU reset, and run-status outputs.
- Sits between the clock tree and the core, replacing direct free-running clocking of the core.

---
 rtl/cpu_run_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle core: turns board-clock TICK pulses
// into CPU clock-enable pulses under GO / STEP_MODE / HALT control, holds
// the core in reset at startup and after a restart, and counts CPU cycles.
//
// Handshake note: there is no valid/ready pair here. TICK is a one-cycle
// strobe sampled on every rising edge, and CPU_CE is a one-cycle strobe that
// the core must consume in the cycle it is high. Both are level-sampled with
// no back-pressure.
module cpu_run_controller #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int RST_HOLD       = 2,
  parameter int CNT_W          = 32
) (
  input  logic             FPGA_GlobalClock,
  input  logic             RST_N,
  input  logic             TICK,
  input  logic             GO,
  input  logic             STEP_MODE,
  input  logic             HALT,
  output logic             CPU_CE,
  output logic             CPU_RST,
  output logic             RUNNING,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] CYCLES
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RH_W = $clog2(RST_HOLD + 1);

  logic             go_s1_q, go_s2_q, sm_s1_q, sm_s2_q;
  logic             go_db_q, go_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             go_press_q, go_press_d;
  logic [2:0]       state_q, state_d;
  logic [RH_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             ce_q, ce_d;
  logic             cpu_rst_q, running_q;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  // Two-flop synchronizers for the asynchronous button and switch.
  always_ff @(posedge FPGA_GlobalClock or negedge RST_N) begin
    if (!RST_N) begin
      go_s1_q <= 1'b0;
      go_s2_q <= 1'b0;
      sm_s1_q <= 1'b0;
      sm_s2_q <= 1'b0;
    end else begin
      go_s1_q <= GO;
      go_s2_q <= go_s1_q;
      sm_s1_q <= STEP_MODE;
      sm_s2_q <= sm_s1_q;
    end
  end

  // Debounce: only TICK samples count; a run of differing samples flips the
  // level, and a rising flip produces a single press pulse.
  always_comb begin
    go_db_d    = go_db_q;
    db_cnt_d   = db_cnt_q;
    go_press_d = 1'b0;
    if (TICK) begin
      if (go_s2_q != go_db_q) begin
        if (db_cnt_q == DB_W'(DEBOUNCE_TICKS - 1)) begin
          go_db_d    = go_s2_q;
          db_cnt_d   = '0;
          go_press_d = go_s2_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  // Debounce registers.
  always_ff @(posedge FPGA_GlobalClock or negedge RST_N) begin
    if (!RST_N) begin
      go_db_q    <= 1'b0;
      db_cnt_q   <= '0;
      go_press_q <= 1'b0;
    end else begin
      go_db_q    <= go_db_d;
      db_cnt_q   <= db_cnt_d;
      go_press_q <= go_press_d;
    end
  end

  // Run-state decisions; CE and the cycle count follow the chosen transition.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    ce_d      = 1'b0;
    cycles_d  = cycles_q;
    case (state_q)
      S_RESET: begin
        if (TICK) begin
          if (rst_cnt_q == RH_W'(RST_HOLD - 1)) begin
            state_d   = S_IDLE;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RH_W'(1);
          end
        end
      end
      S_IDLE: begin
        if (go_press_q) state_d = sm_s2_q ? S_STEP : S_RUN;
      end
      S_RUN: begin
        if (TICK && HALT) begin
          state_d = S_HALTED;
        end else begin
          ce_d = TICK;
          // A press during HALT is dropped so a halting program cannot be
          // paused into IDLE and resumed past its halt point.
          if (go_press_q && !HALT) state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (TICK) begin
          if (HALT) begin
            state_d = S_HALTED;
          end else begin
            ce_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_HALTED: begin
        if (go_press_q) state_d = S_RESET;
      end
      default: state_d = S_RESET;
    endcase
    if (state_d == S_RESET) begin
      cycles_d = '0;
    end else if (ce_d && (cycles_q != '1)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
  end

  // FSM and registered outputs; CPU_RST/RUNNING decode the next state so
  // they change in the same update as STATE.
  always_ff @(posedge FPGA_GlobalClock or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_RESET;
      rst_cnt_q <= '0;
      ce_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      running_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      ce_q      <= ce_d;
      cpu_rst_q <= (state_d == S_RESET);
      running_q <= (state_d == S_RUN);
      cycles_q  <= cycles_d;
    end
  end

  assign CPU_CE  = ce_q;
  assign CPU_RST = cpu_rst_q;
  assign RUNNING = running_q;
  assign STATE   = state_q;
  assign CYCLES  = cycles_q;

endmodule
